// File: rtl/clock_pkg.sv
// Shared definitions for the timekeeping block: digit widths, per-digit
// limits, the HH:MM load word and the one validity check used by every
// load path (current time and alarm alike).
package clock_pkg;

    localparam int HOUR1_W = 2;   // hour tens digit width (0..2)
    localparam int DIGIT_W = 4;   // every other BCD digit

    localparam int SEC1_MAX        = 5;
    localparam int MIN1_MAX        = 5;
    localparam int DIGIT_MAX       = 9;
    localparam int HOUR1_MAX       = 2;
    localparam int HOUR0_MAX_AT_20 = 3;

    typedef struct packed {
        logic [HOUR1_W-1:0] h1;
        logic [DIGIT_W-1:0] h0;
        logic [DIGIT_W-1:0] m1;
        logic [DIGIT_W-1:0] m0;
    } hhmm_t;

    // True when the digit set is a legal 24-hour HH:MM time.
    function automatic logic hhmm_valid(input hhmm_t t);
        logic hour_ok;
        logic min_ok;
        hour_ok = (t.h1 <= HOUR1_W'(HOUR1_MAX)) &&
                  (t.h0 <= DIGIT_W'(DIGIT_MAX)) &&
                  !((t.h1 == HOUR1_W'(HOUR1_MAX)) && (t.h0 > DIGIT_W'(HOUR0_MAX_AT_20)));
        min_ok  = (t.m1 <= DIGIT_W'(MIN1_MAX)) && (t.m0 <= DIGIT_W'(DIGIT_MAX));
        return hour_ok && min_ok;
    endfunction

endpackage

// File: rtl/clock_time_gen_if.sv
// Load bus and time/alarm digit outputs of clock_time_gen.
//   master : user side, drives the load requests and digits, reads the time.
//   slave  : clock_time_gen side.
interface clock_time_gen_if;
    import clock_pkg::*;

    logic               LD_time;
    logic               LD_alarm;
    logic [HOUR1_W-1:0] H_in1;
    logic [DIGIT_W-1:0] H_in0;
    logic [DIGIT_W-1:0] M_in1;
    logic [DIGIT_W-1:0] M_in0;

    logic [HOUR1_W-1:0] c_hour1;
    logic [DIGIT_W-1:0] c_hour0;
    logic [DIGIT_W-1:0] c_min1;
    logic [DIGIT_W-1:0] c_min0;
    logic [DIGIT_W-1:0] c_sec1;
    logic [DIGIT_W-1:0] c_sec0;
    logic [HOUR1_W-1:0] a_hour1;
    logic [DIGIT_W-1:0] a_hour0;
    logic [DIGIT_W-1:0] a_min1;
    logic [DIGIT_W-1:0] a_min0;
    logic               one_sec;
    logic               load_err;

    modport master (
        output LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0,
        input  c_hour1, c_hour0, c_min1, c_min0, c_sec1, c_sec0,
        input  a_hour1, a_hour0, a_min1, a_min0, one_sec, load_err
    );

    modport slave (
        input  LD_time, LD_alarm, H_in1, H_in0, M_in1, M_in0,
        output c_hour1, c_hour0, c_min1, c_min0, c_sec1, c_sec0,
        output a_hour1, a_hour0, a_min1, a_min0, one_sec, load_err
    );

endinterface

// File: rtl/bcd_mod_counter.sv
// Single BCD digit counting 0..MAX and wrapping.
//   clk, reset : clock, async active-low reset
//   en         : advance one step this edge
//   clr        : synchronous clear (wins over ld/en)
//   ld, d      : synchronous load of d (wins over en)
//   q          : digit value
//   carry      : en while at MAX, i.e. this digit wraps on the edge
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               clr,
    input  logic               ld,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic at_max;

    assign at_max = (q == DIGIT_W'(MAX));
    assign carry  = en & at_max;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (ld)
            q <= d;
        else if (en)
            q <= at_max ? '0 : q + 1'b1;
    end

endmodule

// File: rtl/clock_time_gen.sv
// 24-hour BCD clock with prescaler and alarm-time register.
//   clk, reset    : system clock, async active-low reset
//   bus (slave)   : LD_time/LD_alarm level requests with H_in1/H_in0/M_in1/M_in0,
//                   current time c_*, alarm time a_*, one_sec tick pulse,
//                   load_err pulse for a rejected load.
// TICKS_PER_SEC must be >= 2.
module clock_time_gen
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 10
) (
    input  logic            clk,
    input  logic            reset,
    clock_time_gen_if.slave bus
);

    localparam int PRE_W = $clog2(TICKS_PER_SEC);

    logic [PRE_W-1:0]   pre;
    logic               one_sec_q;
    logic               load_err_q;
    logic [HOUR1_W-1:0] hour1;
    logic [DIGIT_W-1:0] hour0;
    logic [HOUR1_W-1:0] al_hour1;
    logic [DIGIT_W-1:0] al_hour0;
    logic [DIGIT_W-1:0] al_min1;
    logic [DIGIT_W-1:0] al_min0;

    hhmm_t din;
    logic  in_ok;
    logic  load_time;
    logic  load_alarm;
    logic  tick_now;
    logic  adv;

    logic [DIGIT_W-1:0] sec0, sec1, min0, min1;
    logic               sec0_c, sec1_c, min0_c, min1_c;

    assign din        = {bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
    assign in_ok      = hhmm_valid(din);
    assign load_time  = bus.LD_time  & in_ok;
    assign load_alarm = bus.LD_alarm & in_ok;
    assign tick_now   = (pre == PRE_W'(TICKS_PER_SEC - 1));
    // A valid time load swallows the tick that would have landed on this edge.
    assign adv        = tick_now & ~load_time;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre        <= '0;
            one_sec_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            // One error pulse per cycle regardless of how many loads are requested.
            load_err_q <= (bus.LD_time | bus.LD_alarm) & ~in_ok;
            if (load_time) begin
                pre       <= '0;
                one_sec_q <= 1'b0;
            end else if (tick_now) begin
                pre       <= '0;
                one_sec_q <= 1'b1;
            end else begin
                pre       <= pre + 1'b1;
                one_sec_q <= 1'b0;
            end
        end
    end

    // Seconds clear on a time load; minutes take the loaded digits.
    bcd_mod_counter #(.MAX(DIGIT_MAX)) u_sec0 (
        .clk(clk), .reset(reset), .en(adv), .clr(load_time), .ld(1'b0), .d('0),
        .q(sec0), .carry(sec0_c)
    );
    bcd_mod_counter #(.MAX(SEC1_MAX)) u_sec1 (
        .clk(clk), .reset(reset), .en(sec0_c), .clr(load_time), .ld(1'b0), .d('0),
        .q(sec1), .carry(sec1_c)
    );
    bcd_mod_counter #(.MAX(DIGIT_MAX)) u_min0 (
        .clk(clk), .reset(reset), .en(sec1_c), .clr(1'b0), .ld(load_time), .d(din.m0),
        .q(min0), .carry(min0_c)
    );
    bcd_mod_counter #(.MAX(MIN1_MAX)) u_min1 (
        .clk(clk), .reset(reset), .en(min0_c), .clr(1'b0), .ld(load_time), .d(din.m1),
        .q(min1), .carry(min1_c)
    );

    // Hours are a pair with a joint 23 -> 00 wrap, so they live here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hour1 <= '0;
            hour0 <= '0;
        end else if (load_time) begin
            hour1 <= din.h1;
            hour0 <= din.h0;
        end else if (min1_c) begin
            if (hour1 == HOUR1_W'(HOUR1_MAX) && hour0 == DIGIT_W'(HOUR0_MAX_AT_20)) begin
                hour1 <= '0;
                hour0 <= '0;
            end else if (hour0 == DIGIT_W'(DIGIT_MAX)) begin
                hour1 <= hour1 + 1'b1;
                hour0 <= '0;
            end else begin
                hour0 <= hour0 + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            al_hour1 <= '0;
            al_hour0 <= '0;
            al_min1  <= '0;
            al_min0  <= '0;
        end else if (load_alarm) begin
            al_hour1 <= din.h1;
            al_hour0 <= din.h0;
            al_min1  <= din.m1;
            al_min0  <= din.m0;
        end
    end

    assign bus.c_hour1  = hour1;
    assign bus.c_hour0  = hour0;
    assign bus.c_min1   = min1;
    assign bus.c_min0   = min0;
    assign bus.c_sec1   = sec1;
    assign bus.c_sec0   = sec0;
    assign bus.a_hour1  = al_hour1;
    assign bus.a_hour0  = al_hour0;
    assign bus.a_min1   = al_min1;
    assign bus.a_min0   = al_min0;
    assign bus.one_sec  = one_sec_q;
    assign bus.load_err = load_err_q;

endmodule

// File: doc/clock_time_gen.md
Name: clock_time_gen

Overview:
- Timekeeping and set-register block that produces the current-time and alarm-time BCD digits consumed by alarm_block (c_hour1/c_hour0/c_min1/c_min0 and a_hour1/a_hour0/a_min1/a_min0).
- Divides the system clock to a 1 s tick and runs a 24-hour BCD clock (HH:MM:SS).
- Holds a user-loaded alarm time.
- Accepts load requests for time and alarm from a shared 4-digit BCD input bus.

Parameters:
- TICKS_PER_SEC, 10, clk cycles per second tick (10 for simulation, board clock rate for synthesis); must be >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- LD_time  input  1  load current time from H_in/M_in (level, sampled each clk).
- LD_alarm  input  1  load alarm time from H_in/M_in (level, sampled each clk).
- H_in1  input  2  hour tens digit to load (BCD).
- H_in0  input  4  hour units digit to load (BCD).
- M_in1  input  4  minute tens digit to load (BCD).
- M_in0  input  4  minute units digit to load (BCD).
- c_hour1  output  2  current hour tens.
- c_hour0  output  4  current hour units.
- c_min1  output  4  current minute tens.
- c_min0  output  4  current minute units.
- c_sec1  output  4  current second tens.
- c_sec0  output  4  current second units.
- a_hour1  output  2  alarm hour tens.
- a_hour0  output  4  alarm hour units.
- a_min1  output  4  alarm minute tens.
- a_min0  output  4  alarm minute units.
- one_sec  output  1  one-cycle pulse on each second tick.
- load_err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (reset=0, asynchronous): prescaler=0; all c_* and a_* digits=0; one_sec=0; load_err=0. Counting resumes on the first clk edge after release.
- Prescaler: counts 0..TICKS_PER_SEC-1 and wraps.
  - one_sec is registered and asserted for exactly 1 cycle, in the cycle after the prescaler reaches TICKS_PER_SEC-1.
  - Time advances on the same edge that raises one_sec.
- BCD time advance on a tick:
  - sec0 9->0 carries into sec1.
  - sec1 5->0 carries into min0.
  - min0 9->0 carries into min1.
  - min1 5->0 carries into the hour.
  - Hour sequence: 09->10, 19->20, 23->00. 23:59:59 -> 00:00:00 in a single tick.
- Input validity: H_in1<=2, H_in0<=9, (H_in1==2 implies H_in0<=3), M_in1<=5, M_in0<=9.
- LD_time=1 with valid input:
  - Next edge: c_hour/c_min take the input digits; c_sec1=c_sec0=0; prescaler=0; no tick is generated on that edge.
  - Holding LD_time keeps the clock frozen at the loaded value.
- LD_alarm=1 with valid input: next edge loads a_* digits. The clock keeps running.
- Invalid input while either load is asserted:
  - No register changes for the requested load.
  - The clock keeps running as if no LD_time were asserted.
  - load_err pulses 1 cycle. When the load is held, load_err re-pulses every cycle it stays asserted with bad input.
- Simultaneous LD_time and LD_alarm: both load the same digits on the same edge; a single load_err on invalid input.
- Priority: reset > LD_time > tick advance. LD_alarm is independent of the tick.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-count or mid-load returns every output to 0 immediately.

Decomposition:
- Shared package clock_pkg holds:
  - digit limits: SEC1_MAX=5, MIN1_MAX=5, DIGIT_MAX=9, HOUR1_MAX=2, HOUR0_MAX_AT_20=3;
  - the time-digit field widths (2 and 4);
  - a validity function for an HH:MM digit set, so load validity checks share one definition.
- One sub-module, bcd_mod_counter:
  - Parameter: MAX. Inputs: clk, reset, en, clr. Outputs: q[3:0], carry.
  - Instantiated for the sec0, sec1, min0 and min1 digits.
  - Hour logic stays in the top because of its 23->00 rule.

Test Plan:
- Reset with TICKS_PER_SEC=10: all digits 0 and one_sec=0 while reset=0. After release, the first one_sec pulse occurs 10 cycles later and c_sec0=1.
- Load 12:34 via LD_time for 1 cycle: c_hour1=1, c_hour0=2, c_min1=3, c_min0=4, seconds=0. After 60 ticks, time reads 12:35:00.
- Load 23:59 and run 60 ticks: time reads 00:00:00 and a_* digits are unchanged. Also check 09:59:59->10:00:00 and 19:59:59->20:00:00.
- LD_alarm with 06:30 while the clock runs: a_hour0=6, a_min1=3; current time keeps advancing with no lost tick.
- Invalid inputs 24:00, 12:60 and 1A(hour0=10):00 on LD_time: load_err pulses once each; time and alarm registers are unchanged.
- LD_time and LD_alarm together with 07:45, then reset asserted mid-second: both sets read 07:45; then every output becomes 0 asynchronously.
